// File: rtl/instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch
// Purpose  : Instruction fetch front end. Issues word-aligned fetch requests,
//            collects in-order memory responses into a small FIFO that feeds
//            decode, drops stale responses after a redirect, and stops
//            fetching after an access fault until the next redirect.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch #(
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          BUF_DEPTH = 2
) (
   input  logic        clk,
   input  logic        rstn,
   output logic        imem_req_valid,
   input  logic        imem_req_ready,
   output logic [31:0] imem_req_addr,
   input  logic        imem_rsp_valid,
   input  logic [31:0] imem_rsp_data,
   input  logic        imem_rsp_err,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_pc,
   output logic [31:0] id_instr,
   output logic        id_fault
);

   localparam int               PTR_W       = $clog2(BUF_DEPTH);
   localparam int               CNT_W       = $clog2(BUF_DEPTH + 1);
   localparam logic [31:0]      FAULT_INSTR = 32'h0000_0013;
   localparam logic [PTR_W-1:0] LAST_PTR    = PTR_W'(BUF_DEPTH - 1);
   localparam logic [CNT_W:0]   DEPTH_W     = (CNT_W + 1)'(BUF_DEPTH);

   typedef enum logic [0:0] {
      ST_RUN   = 1'b0,
      ST_FAULT = 1'b1
   } state_t;

   state_t           state;
   logic [31:0]      fetch_pc;
   logic [31:0]      rsp_pc;       // PC belonging to the next response that will be kept
   logic [CNT_W-1:0] outstanding;
   logic [CNT_W-1:0] drop_cnt;
   logic [CNT_W-1:0] buf_count;
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;

   logic [31:0]      buf_pc    [BUF_DEPTH];
   logic [31:0]      buf_instr [BUF_DEPTH];
   logic             buf_fault [BUF_DEPTH];

   logic             req_fire;
   logic             pop;
   logic             push;
   logic [CNT_W:0]   occupancy;
   logic [31:0]      redirect_target;
   logic             unused_redirect_lsbs;

   function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
      return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
   endfunction

   assign redirect_target      = {redirect_pc[31:2], 2'b00};
   assign unused_redirect_lsbs = ^redirect_pc[1:0];

   // A slot freed by this cycle's pop counts as available, which keeps the
   // pipe at one instruction per cycle while still reserving a buffer slot
   // for every response that can come back.
   assign pop       = id_valid && id_ready;
   assign occupancy = {1'b0, outstanding} + {1'b0, buf_count} - {{CNT_W{1'b0}}, pop};

   assign imem_req_valid = rstn && (state == ST_RUN) && !redirect_valid && (occupancy < DEPTH_W);
   assign imem_req_addr  = fetch_pc;
   assign req_fire       = imem_req_valid && imem_req_ready;

   // Responses are kept only when nothing stale is pending, fetch is running
   // and no redirect is flushing the pipe this cycle.
   assign push = imem_rsp_valid && !redirect_valid && (drop_cnt == '0) && (state == ST_RUN);

   assign id_valid = (buf_count != '0);
   assign id_pc    = id_valid ? buf_pc[rd_ptr]    : 32'h0;
   assign id_instr = id_valid ? buf_instr[rd_ptr] : 32'h0;
   assign id_fault = id_valid ? buf_fault[rd_ptr] : 1'b0;

   // Control state: fetch PC, counters, FIFO pointers and the RUN/FAULT FSM.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state       <= ST_RUN;
         fetch_pc    <= RESET_PC;
         rsp_pc      <= RESET_PC;
         outstanding <= '0;
         drop_cnt    <= '0;
         buf_count   <= '0;
         rd_ptr      <= '0;
         wr_ptr      <= '0;
      end else begin
         if (req_fire && !imem_rsp_valid) begin
            outstanding <= outstanding + CNT_W'(1);
         end else if (!req_fire && imem_rsp_valid) begin
            outstanding <= outstanding - CNT_W'(1);
         end

         if (redirect_valid) begin
            // Everything still in flight after this cycle's response is stale.
            fetch_pc  <= redirect_target;
            rsp_pc    <= redirect_target;
            state     <= ST_RUN;
            drop_cnt  <= outstanding - CNT_W'(imem_rsp_valid);
            buf_count <= '0;
            rd_ptr    <= '0;
            wr_ptr    <= '0;
         end else begin
            if (req_fire) begin
               fetch_pc <= fetch_pc + 32'd4;
            end
            if (imem_rsp_valid && (drop_cnt != '0)) begin
               drop_cnt <= drop_cnt - CNT_W'(1);
            end
            if (push) begin
               wr_ptr <= ptr_inc(wr_ptr);
               rsp_pc <= rsp_pc + 32'd4;
               if (imem_rsp_err) begin
                  state <= ST_FAULT;
               end
            end
            if (pop) begin
               rd_ptr <= ptr_inc(rd_ptr);
            end
            if (push && !pop) begin
               buf_count <= buf_count + CNT_W'(1);
            end else if (!push && pop) begin
               buf_count <= buf_count - CNT_W'(1);
            end
         end
      end
   end

   // FIFO storage; validity is tracked by buf_count so no reset is needed.
   always_ff @(posedge clk) begin
      if (push) begin
         buf_pc[wr_ptr]    <= rsp_pc;
         buf_instr[wr_ptr] <= imem_rsp_err ? FAULT_INSTR : imem_rsp_data;
         buf_fault[wr_ptr] <= imem_rsp_err;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch
// Purpose  : Self-checking bench for instr_fetch with a latency-randomised
//            memory model and a scoreboard of expected decode entries.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch;

   localparam int          DEPTH    = 2;
   localparam logic [31:0] NOP      = 32'h0000_0013;
   localparam logic [31:0] NO_ERR   = 32'h0000_0001;  // unaligned, never matches

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_req_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rsp_data  = 32'h0;
   logic        imem_rsp_err   = 1'b0;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc    = 32'h0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_pc;
   logic [31:0] id_instr;
   logic        id_fault;

   instr_fetch #(.RESET_PC(32'h0000_0000), .BUF_DEPTH(DEPTH)) dut (
      .clk            (clk),
      .rstn           (rstn),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_req_addr  (imem_req_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rsp_data  (imem_rsp_data),
      .imem_rsp_err   (imem_rsp_err),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_pc          (id_pc),
      .id_instr       (id_instr),
      .id_fault       (id_fault)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } dec_t;
   typedef struct { logic [31:0] addr; logic err; int due; int epoch; } mem_t;

   dec_t        exp_q[$];
   mem_t        mem_q[$];
   logic [31:0] acc_addrs[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          epoch = 0;
   int          last_due = 0;
   int          buffered = 0;
   int          pops = 0;
   int          first_req_cyc = -1;
   int          first_idv_cyc = -1;
   logic [31:0] exp_fetch_pc = 32'h0;
   logic [31:0] err_addr = NO_ERR;
   logic        fault_req_seen = 1'b0;
   logic        fault_state = 1'b0;
   logic        clear_pending = 1'b0;
   logic        redir_req = 1'b0;
   logic [31:0] redir_target = 32'h0;
   int          lat_lo = 1, lat_hi = 1, rdy_pct = 100, idr_pct = 100;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // One clock cycle of memory model, stimulus and reference model, entered at a negedge.
   task automatic cycle_body();
      mem_t m;
      logic rsp, acc, pop, push, redir;
      int   due;
      cyc++;
      if (clear_pending) begin
         exp_q.delete();
         clear_pending = 1'b0;
      end
      rsp = 1'b0;
      m = '{addr: 32'h0, err: 1'b0, due: 0, epoch: -1};
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = 32'h0;
      imem_rsp_err   = 1'b0;
      if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
         m = mem_q.pop_front();
         rsp = 1'b1;
         imem_rsp_valid = 1'b1;
         imem_rsp_data  = mem_word(m.addr);
         imem_rsp_err   = m.err;
      end
      redir          = redir_req;
      redir_req      = 1'b0;
      redirect_valid = redir;
      redirect_pc    = redir_target;
      imem_req_ready = ($urandom_range(99) < rdy_pct);
      id_ready       = ($urandom_range(99) < idr_pct);
      #1;
      check("id_valid_vs_model", id_valid, buffered > 0);
      if (fault_state) check("no_req_in_fault", imem_req_valid, 0);
      if (redir) check("no_req_in_redirect", imem_req_valid, 0);
      if (imem_req_valid && first_req_cyc < 0) first_req_cyc = cyc;
      if (id_valid && first_idv_cyc < 0) first_idv_cyc = cyc;
      acc = imem_req_valid && imem_req_ready;
      if (acc) begin
         check("req_addr", imem_req_addr, exp_fetch_pc);
         acc_addrs.push_back(imem_req_addr);
         due = cyc + $urandom_range(lat_hi, lat_lo);
         if (due <= last_due) due = last_due + 1;
         last_due = due;
         mem_q.push_back('{addr: imem_req_addr, err: (imem_req_addr == err_addr), due: due, epoch: epoch});
         if (!fault_req_seen) begin
            if (exp_fetch_pc == err_addr) begin
               exp_q.push_back('{pc: exp_fetch_pc, instr: NOP, fault: 1'b1});
               fault_req_seen = 1'b1;
            end else begin
               exp_q.push_back('{pc: exp_fetch_pc, instr: mem_word(exp_fetch_pc), fault: 1'b0});
            end
         end
         exp_fetch_pc = exp_fetch_pc + 32'd4;
      end
      pop  = id_valid && id_ready;
      push = rsp && (m.epoch == epoch) && !fault_state && !redir;
      if (pop) pops++;
      if (push && m.err) fault_state = 1'b1;
      buffered = buffered + int'(push) - int'(pop);
      if (redir) begin
         epoch++;
         buffered       = 0;
         fault_state    = 1'b0;
         fault_req_seen = 1'b0;
         exp_fetch_pc   = {redirect_pc[31:2], 2'b00};
         clear_pending  = 1'b1;
         acc_addrs.delete();
      end
      check("occupancy_le_depth", (mem_q.size() + buffered) <= DEPTH, 1);
   endtask

   task automatic cycle(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         cycle_body();
      end
   endtask

   task automatic redirect_to(input logic [31:0] target, input logic [31:0] new_err);
      redir_req    = 1'b1;
      redir_target = target;
      err_addr     = new_err;
   endtask

   task automatic do_reset();
      rstn = 1'b0;
      imem_req_ready = 1'b0;
      imem_rsp_valid = 1'b0;
      imem_rsp_err   = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      mem_q.delete();
      exp_q.delete();
      acc_addrs.delete();
      epoch++;
      buffered = 0; fault_state = 1'b0; fault_req_seen = 1'b0; clear_pending = 1'b0;
      redir_req = 1'b0; exp_fetch_pc = 32'h0; err_addr = NO_ERR;
      first_req_cyc = -1; first_idv_cyc = -1;
      repeat (2) @(negedge clk);
      #1;
      check("rst_req_valid", imem_req_valid, 0);
      check("rst_id_valid", id_valid, 0);
      check("rst_id_pc", id_pc, 0);
      check("rst_id_instr", id_instr, 0);
      check("rst_id_fault", id_fault, 0);
      pops = 0;
      @(negedge clk);
      rstn = 1'b1;
      cycle_body();
   endtask

   task automatic check_first_acc(input string name, input logic [31:0] exp);
      if (acc_addrs.size() == 0) check(name, 32'hDEAD_DEAD, exp);
      else check(name, acc_addrs[0], exp);
   endtask

   // Scoreboard monitor: every decode handshake pops and compares one expected entry.
   initial begin
      dec_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rstn && id_valid && id_ready) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_decode: got pc %h, expected no entry (cycle %0d)", id_pc, cyc);
            end else begin
               e = exp_q.pop_front();
               check("id_pc", id_pc, e.pc);
               check("id_instr", id_instr, e.instr);
               check("id_fault", id_fault, e.fault);
            end
         end
      end
   end

   initial begin
      // Reset, 1-cycle memory, decode always ready: 2-cycle latency, 1/cycle.
      lat_lo = 1; lat_hi = 1; rdy_pct = 100; idr_pct = 100;
      do_reset();
      cycle(9);
      check("first_id_valid_latency", first_idv_cyc - first_req_cyc, 2);
      check("throughput_pops", pops, 8);

      // Decode stall: requests must stop once the buffer budget is used.
      idr_pct = 0;
      cycle(5);
      check("req_dropped_on_stall", imem_req_valid, 0);
      idr_pct = 100;
      cycle(8);

      // Redirect with two responses in flight.
      lat_lo = 3; lat_hi = 3;
      cycle(6);
      redirect_to(32'h0000_0103, NO_ERR);
      cycle(12);
      check_first_acc("redirect_first_addr", 32'h0000_0100);

      // Access fault at 0x8, then resume at 0x200.
      lat_lo = 1; lat_hi = 1;
      redirect_to(32'h0000_0000, 32'h0000_0008);
      cycle(12);
      check("fault_stops_fetch", imem_req_valid, 0);
      redirect_to(32'h0000_0200, NO_ERR);
      cycle(8);
      check_first_acc("resume_first_addr", 32'h0000_0200);

      // Fetch PC wrap-around.
      redirect_to(32'hFFFF_FFF8, NO_ERR);
      cycle(8);
      if (acc_addrs.size() < 3) check("wrap_req_count", acc_addrs.size(), 3);
      else begin
         check("wrap_addr0", acc_addrs[0], 32'hFFFF_FFF8);
         check("wrap_addr1", acc_addrs[1], 32'hFFFF_FFFC);
         check("wrap_addr2", acc_addrs[2], 32'h0000_0000);
      end

      // Random latency/readiness with random redirects and faults, then a mid-run reset.
      lat_lo = 1; lat_hi = 4; rdy_pct = 60; idr_pct = 70;
      for (int pass = 0; pass < 2; pass++) begin
         for (int i = 0; i < 400; i++) begin
            if ($urandom_range(99) < 5) begin
               logic [31:0] t, k, e;
               t = $urandom;
               k = $urandom_range(5);
               e = ($urandom_range(99) < 30) ? ({t[31:2], 2'b00} + (k << 2)) : NO_ERR;
               redirect_to(t, e);
            end
            cycle(1);
         end
         if (pass == 0) begin
            do_reset();
            lat_lo = 1; lat_hi = 4; rdy_pct = 60; idr_pct = 70;
         end
      end

      // Drain: no new requests, decode ready, everything expected must appear.
      rdy_pct = 0; idr_pct = 100;
      cycle(20);
      check("leftover_expected", exp_q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
